// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle: pipeline status flowing into pipe_hazard_ctrl and the
// pause / clear / kill controls it returns to the pipeline register block.
interface pipe_hazard_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       de_valid;
  logic       de_is_load;
  logic       de_is_muldiv;
  logic [4:0] de_dst;
  logic       md_done;
  logic       el_valid;
  logic       el_is_mem;
  logic       el_taken;
  logic       lsu_mem_ack;
  logic       trap_req;

  logic       pause_ifu;
  logic       pause_dfu;
  logic       pause_exu;
  logic       pause_lsu;
  logic       pause_wbu;
  logic       clear_id;
  logic       clear_de;
  logic       clear_el;
  logic       clear_lw;
  logic       clear_all;
  logic       clear_before_lw;
  logic       id_clk_en;
  logic       de_clk_en;
  logic       el_clk_en;
  logic       lw_clk_en;
  logic       md_kill;
  logic       lsu_timeout_err;
  logic [2:0] ctrl_state;

  // master: pipeline side reporting status; slave: the hazard controller
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           de_valid, de_is_load, de_is_muldiv, de_dst, md_done,
           el_valid, el_is_mem, el_taken, lsu_mem_ack, trap_req,
    input  pause_ifu, pause_dfu, pause_exu, pause_lsu, pause_wbu,
           clear_id, clear_de, clear_el, clear_lw, clear_all, clear_before_lw,
           id_clk_en, de_clk_en, el_clk_en, lw_clk_en,
           md_kill, lsu_timeout_err, ctrl_state
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           de_valid, de_is_load, de_is_muldiv, de_dst, md_done,
           el_valid, el_is_mem, el_taken, lsu_mem_ack, trap_req,
    output pause_ifu, pause_dfu, pause_exu, pause_lsu, pause_wbu,
           clear_id, clear_de, clear_el, clear_lw, clear_all, clear_before_lw,
           id_clk_en, de_clk_en, el_clk_en, lw_clk_en,
           md_kill, lsu_timeout_err, ctrl_state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use, mul/div, memory-wait, branch and trap.
// Define PIPE_CTRL_LSU_TIMEOUT_EN to build the memory wait counter and timeout.
module pipe_hazard_ctrl #(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned LSU_TIMEOUT      = 255
) (
  input logic             core_clk,
  input logic             core_rst,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    LU_STALL = 3'd1,
    MD_WAIT  = 3'd2,
    MEM_WAIT = 3'd3,
    TRAP     = 3'd4
  } state_e;

  if (LOAD_USE_BUBBLES < 1 || LOAD_USE_BUBBLES > 7) begin : g_bad_bubbles
    $error("LOAD_USE_BUBBLES out of range 1..7");
  end
  if (LSU_TIMEOUT < 1 || LSU_TIMEOUT > 1023) begin : g_bad_timeout
    $error("LSU_TIMEOUT out of range 1..1023");
  end

  state_e     state_q, state_d;
  logic [2:0] lu_cnt_q, lu_cnt_d;
  logic [3:0] clk_en_q, clk_en_d;

  logic lu_haz, md_haz, mem_haz, br_taken;
  logic mem_act, md_act, lu_act;
  logic stall_dfu, stall_exu, stall_lsu;
  logic clear_all_c, clear_before_lw_c, md_kill_c;
  logic mem_stall;
  logic timeout_err;
  logic live;

  assign lu_haz = hz.de_valid & hz.de_is_load & (hz.de_dst != 5'd0) & hz.id_valid &
                  ((hz.id_use_rs1 & (hz.id_rs1 == hz.de_dst)) |
                   (hz.id_use_rs2 & (hz.id_rs2 == hz.de_dst)));
  assign md_haz   = hz.de_valid & hz.de_is_muldiv & ~hz.md_done;
  assign mem_haz  = hz.el_valid & hz.el_is_mem & ~hz.lsu_mem_ack;
  assign br_taken = hz.el_valid & hz.el_taken;

  // Inside a wait state the hold depends only on its completion input.
  assign mem_act = (state_q == MEM_WAIT) ? ~hz.lsu_mem_ack : mem_haz;
  assign md_act  = (state_q == MD_WAIT)  ? ~hz.md_done     : md_haz;
  assign lu_act  = (state_q == LU_STALL) | lu_haz;

  always_comb begin
    state_d           = state_q;
    lu_cnt_d          = lu_cnt_q;
    stall_dfu         = 1'b0;
    stall_exu         = 1'b0;
    stall_lsu         = 1'b0;
    clear_all_c       = 1'b0;
    clear_before_lw_c = 1'b0;
    md_kill_c         = 1'b0;
    mem_stall         = 1'b0;
    if (hz.trap_req || timeout_err) begin
      clear_all_c = 1'b1;
      state_d     = TRAP;
      lu_cnt_d    = '0;
    end else if (state_q == TRAP) begin
      state_d = RUN;
    end else if (mem_act) begin
      stall_lsu = 1'b1;
      mem_stall = 1'b1;
      state_d   = MEM_WAIT;
      lu_cnt_d  = '0;
    end else if (br_taken) begin
      clear_before_lw_c = 1'b1;
      md_kill_c         = (state_q == MD_WAIT);
      state_d           = RUN;
      lu_cnt_d          = '0;
    end else if (md_act) begin
      stall_exu = 1'b1;
      state_d   = MD_WAIT;
      lu_cnt_d  = '0;
    end else if (lu_act) begin
      stall_dfu = 1'b1;
      if (state_q == LU_STALL) begin
        lu_cnt_d = lu_cnt_q - 3'd1;
        state_d  = (lu_cnt_q == 3'd1) ? RUN : LU_STALL;
      end else if (LOAD_USE_BUBBLES > 1) begin
        lu_cnt_d = 3'(LOAD_USE_BUBBLES - 1);
        state_d  = LU_STALL;
      end else begin
        state_d = RUN;
      end
    end else begin
      state_d = RUN;
    end
  end

`ifdef PIPE_CTRL_LSU_TIMEOUT_EN
  logic [9:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;

  // Counter saturates at the limit; the flag fires the following cycle.
  always_comb begin
    wait_cnt_d = '0;
    timeout_d  = 1'b0;
    if (mem_stall) begin
      if (wait_cnt_q == 10'(LSU_TIMEOUT)) begin
        timeout_d  = 1'b1;
        wait_cnt_d = wait_cnt_q;
      end else begin
        wait_cnt_d = wait_cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign clk_en_d = '1;

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q  <= RUN;
      lu_cnt_q <= '0;
      clk_en_q <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
      clk_en_q <= clk_en_d;
    end
  end

  // Mealy outputs are gated so reset silences them even with hazards present.
  assign live = ~core_rst;

  assign hz.pause_wbu       = 1'b0;
  assign hz.pause_lsu       = live & stall_lsu;
  assign hz.pause_exu       = live & (stall_lsu | stall_exu);
  assign hz.pause_dfu       = live & (stall_lsu | stall_exu | stall_dfu);
  assign hz.pause_ifu       = live & (stall_lsu | stall_exu | stall_dfu);
  assign hz.clear_id        = 1'b0;
  assign hz.clear_de        = 1'b0;
  assign hz.clear_el        = 1'b0;
  assign hz.clear_lw        = 1'b0;
  assign hz.clear_all       = live & clear_all_c;
  assign hz.clear_before_lw = live & clear_before_lw_c;
  assign hz.md_kill         = live & md_kill_c;
  assign hz.lsu_timeout_err = timeout_err;
  assign hz.id_clk_en       = clk_en_q[3];
  assign hz.de_clk_en       = clk_en_q[2];
  assign hz.el_clk_en       = clk_en_q[1];
  assign hz.lw_clk_en       = clk_en_q[0];
  assign hz.ctrl_state      = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: two instances (1 and 3 load-use bubbles)
// share stimulus; expected output vectors are queued per cycle and checked at negedge.
module tb_pipe_hazard_ctrl;

  logic core_clk;
  logic core_rst;

  pipe_hazard_ctrl_if ifa ();
  pipe_hazard_ctrl_if ifb ();

  assign ifb.id_valid     = ifa.id_valid;
  assign ifb.id_rs1       = ifa.id_rs1;
  assign ifb.id_rs2       = ifa.id_rs2;
  assign ifb.id_use_rs1   = ifa.id_use_rs1;
  assign ifb.id_use_rs2   = ifa.id_use_rs2;
  assign ifb.de_valid     = ifa.de_valid;
  assign ifb.de_is_load   = ifa.de_is_load;
  assign ifb.de_is_muldiv = ifa.de_is_muldiv;
  assign ifb.de_dst       = ifa.de_dst;
  assign ifb.md_done      = ifa.md_done;
  assign ifb.el_valid     = ifa.el_valid;
  assign ifb.el_is_mem    = ifa.el_is_mem;
  assign ifb.el_taken     = ifa.el_taken;
  assign ifb.lsu_mem_ack  = ifa.lsu_mem_ack;
  assign ifb.trap_req     = ifa.trap_req;

  pipe_hazard_ctrl #(.LOAD_USE_BUBBLES(1), .LSU_TIMEOUT(8)) u_dut_a (
    .core_clk (core_clk),
    .core_rst (core_rst),
    .hz       (ifa)
  );

  pipe_hazard_ctrl #(.LOAD_USE_BUBBLES(3), .LSU_TIMEOUT(8)) u_dut_b (
    .core_clk (core_clk),
    .core_rst (core_rst),
    .hz       (ifb)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P_DFU  = 5'b00011;
  localparam logic [4:0] P_EXU  = 5'b00111;
  localparam logic [4:0] P_LSU  = 5'b01111;
  localparam logic [2:0] S_RUN  = 3'd0;
  localparam logic [2:0] S_LU   = 3'd1;
  localparam logic [2:0] S_MD   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_TRAP = 3'd4;

  // {clear_id,de,el,lw}, {clk_en id,de,el,lw}, state, timeout, kill, clear_all, clear_before_lw, pauses
  logic [19:0] obs_a, obs_b;
  assign obs_a = {ifa.clear_id, ifa.clear_de, ifa.clear_el, ifa.clear_lw,
                  ifa.id_clk_en, ifa.de_clk_en, ifa.el_clk_en, ifa.lw_clk_en,
                  ifa.ctrl_state, ifa.lsu_timeout_err, ifa.md_kill, ifa.clear_all,
                  ifa.clear_before_lw,
                  ifa.pause_wbu, ifa.pause_lsu, ifa.pause_exu, ifa.pause_dfu, ifa.pause_ifu};
  assign obs_b = {ifb.clear_id, ifb.clear_de, ifb.clear_el, ifb.clear_lw,
                  ifb.id_clk_en, ifb.de_clk_en, ifb.el_clk_en, ifb.lw_clk_en,
                  ifb.ctrl_state, ifb.lsu_timeout_err, ifb.md_kill, ifb.clear_all,
                  ifb.clear_before_lw,
                  ifb.pause_wbu, ifb.pause_lsu, ifb.pause_exu, ifb.pause_dfu, ifb.pause_ifu};

  typedef struct {
    string       tag;
    logic [19:0] ea;
    logic [19:0] eb;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks;
  int   n_pass;
  logic exp_en;

  task automatic check_eq(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %05h expected %05h", tag, obs, exp);
  endtask

  function automatic logic [19:0] ev(input logic [4:0] pz, input logic cbl, input logic ca,
                                     input logic mk, input logic te, input logic [2:0] st);
    return {4'b0000, {4{exp_en}}, st, te, mk, ca, cbl, pz};
  endfunction

  always @(negedge core_clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check_eq({mon_e.tag, "/a"}, obs_a, mon_e.ea);
      check_eq({mon_e.tag, "/b"}, obs_b, mon_e.eb);
    end
  end

  task automatic drive2(input string tag, input logic [19:0] ea, input logic [19:0] eb);
    exp_t e;
    e.tag = tag;
    e.ea  = ea;
    e.eb  = eb;
    sb_q.push_back(e);
    @(posedge core_clk);
    #1;
  endtask

  task automatic drive(input string tag, input logic [19:0] e);
    drive2(tag, e, e);
  endtask

  task automatic idle();
    ifa.id_valid     = 1'b0;
    ifa.id_rs1       = 5'd0;
    ifa.id_rs2       = 5'd0;
    ifa.id_use_rs1   = 1'b0;
    ifa.id_use_rs2   = 1'b0;
    ifa.de_valid     = 1'b0;
    ifa.de_is_load   = 1'b0;
    ifa.de_is_muldiv = 1'b0;
    ifa.de_dst       = 5'd0;
    ifa.md_done      = 1'b0;
    ifa.el_valid     = 1'b0;
    ifa.el_is_mem    = 1'b0;
    ifa.el_taken     = 1'b0;
    ifa.lsu_mem_ack  = 1'b0;
    ifa.trap_req     = 1'b0;
  endtask

  task automatic lu_inputs();
    ifa.id_valid   = 1'b1;
    ifa.id_rs1     = 5'd5;
    ifa.id_use_rs1 = 1'b1;
    ifa.de_valid   = 1'b1;
    ifa.de_is_load = 1'b1;
    ifa.de_dst     = 5'd5;
  endtask

  task automatic md_inputs();
    ifa.de_valid     = 1'b1;
    ifa.de_is_muldiv = 1'b1;
  endtask

  task automatic mem_inputs();
    ifa.el_valid  = 1'b1;
    ifa.el_is_mem = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_en   = 1'b0;
    core_rst = 1'b1;
    idle();
    @(posedge core_clk);
    #1;

    // reset dominates every hazard input
    ifa.trap_req = 1'b1;
    mem_inputs();
    lu_inputs();
    drive("rst_hold", ev(P_NONE, 0, 0, 0, 0, S_RUN));
    drive("rst_hold2", ev(P_NONE, 0, 0, 0, 0, S_RUN));
    idle();
    core_rst = 1'b0;
    drive("rst_rel", ev(P_NONE, 0, 0, 0, 0, S_RUN));
    exp_en = 1'b1;
    drive("clk_en_up", ev(P_NONE, 0, 0, 0, 0, S_RUN));

    // load-use x5 -> x5: one bubble on a, three on b
    lu_inputs();
    drive("lu0", ev(P_DFU, 0, 0, 0, 0, S_RUN));
    idle();
    drive2("lu1", ev(P_NONE, 0, 0, 0, 0, S_RUN), ev(P_DFU, 0, 0, 0, 0, S_LU));
    drive2("lu2", ev(P_NONE, 0, 0, 0, 0, S_RUN), ev(P_DFU, 0, 0, 0, 0, S_LU));
    drive("lu3", ev(P_NONE, 0, 0, 0, 0, S_RUN));

    lu_inputs();
    ifa.id_rs1 = 5'd0;
    ifa.de_dst = 5'd0;
    drive("lu_x0", ev(P_NONE, 0, 0, 0, 0, S_RUN));
    ifa.id_rs1 = 5'd3;
    ifa.id_rs2 = 5'd5;
    ifa.de_dst = 5'd5;
    drive("lu_nouse", ev(P_NONE, 0, 0, 0, 0, S_RUN));
    ifa.id_use_rs2 = 1'b1;
    drive("lu_rs2", ev(P_DFU, 0, 0, 0, 0, S_RUN));
    idle();
    ifa.el_valid = 1'b1;
    ifa.el_taken = 1'b1;
    drive2("lu_flush", ev(P_NONE, 1, 0, 0, 0, S_RUN), ev(P_NONE, 1, 0, 0, 0, S_LU));
    idle();
    drive("lu_flush_after", ev(P_NONE, 0, 0, 0, 0, S_RUN));

    // mul/div with md_done on cycle 33
    md_inputs();
    drive("md0", ev(P_EXU, 0, 0, 0, 0, S_RUN));
    for (int i = 1; i <= 32; i++) drive("md_wait", ev(P_EXU, 0, 0, 0, 0, S_MD));
    ifa.md_done = 1'b1;
    drive("md_done", ev(P_NONE, 0, 0, 0, 0, S_MD));
    idle();
    drive("md_after", ev(P_NONE, 0, 0, 0, 0, S_RUN));

    // branch flush during MD_WAIT, then flush coinciding with md_done
    md_inputs();
    drive("mdf0", ev(P_EXU, 0, 0, 0, 0, S_RUN));
    drive("mdf1", ev(P_EXU, 0, 0, 0, 0, S_MD));
    ifa.el_valid = 1'b1;
    ifa.el_taken = 1'b1;
    drive("mdf_flush", ev(P_NONE, 1, 0, 1, 0, S_MD));
    idle();
    drive("mdf_after", ev(P_NONE, 0, 0, 0, 0, S_RUN));
    md_inputs();
    drive("mdd0", ev(P_EXU, 0, 0, 0, 0, S_RUN));
    drive("mdd1", ev(P_EXU, 0, 0, 0, 0, S_MD));
    ifa.md_done  = 1'b1;
    ifa.el_valid = 1'b1;
    ifa.el_taken = 1'b1;
    drive("mdd_flush", ev(P_NONE, 1, 0, 1, 0, S_MD));
    idle();
    drive("mdd_after", ev(P_NONE, 0, 0, 0, 0, S_RUN));

    // memory wait, ack after 4 cycles
    mem_inputs();
    drive("mem0", ev(P_LSU, 0, 0, 0, 0, S_RUN));
    for (int i = 1; i <= 3; i++) drive("mem_wait", ev(P_LSU, 0, 0, 0, 0, S_MEM));
    ifa.lsu_mem_ack = 1'b1;
    drive("mem_ack", ev(P_NONE, 0, 0, 0, 0, S_MEM));
    idle();
    drive("mem_after", ev(P_NONE, 0, 0, 0, 0, S_RUN));

`ifdef PIPE_CTRL_LSU_TIMEOUT_EN
    mem_inputs();
    drive("to0", ev(P_LSU, 0, 0, 0, 0, S_RUN));
    for (int i = 1; i <= 8; i++) drive("to_wait", ev(P_LSU, 0, 0, 0, 0, S_MEM));
    drive("to_pulse", ev(P_NONE, 0, 1, 0, 1, S_MEM));
    idle();
    drive("to_trap", ev(P_NONE, 0, 0, 0, 0, S_TRAP));
    drive("to_run", ev(P_NONE, 0, 0, 0, 0, S_RUN));
`else
    mem_inputs();
    drive("nto0", ev(P_LSU, 0, 0, 0, 0, S_RUN));
    for (int i = 1; i <= 19; i++) drive("nto_wait", ev(P_LSU, 0, 0, 0, 0, S_MEM));
    ifa.lsu_mem_ack = 1'b1;
    drive("nto_ack", ev(P_NONE, 0, 0, 0, 0, S_MEM));
    idle();
    drive("nto_after", ev(P_NONE, 0, 0, 0, 0, S_RUN));
`endif

    // trap during MD_WAIT; TRAP state ignores a fresh memory hazard
    md_inputs();
    drive("trp0", ev(P_EXU, 0, 0, 0, 0, S_RUN));
    ifa.trap_req = 1'b1;
    drive("trp_req", ev(P_NONE, 0, 1, 0, 0, S_MD));
    idle();
    mem_inputs();
    drive("trp_state", ev(P_NONE, 0, 0, 0, 0, S_TRAP));
    drive("trp_run_mem", ev(P_LSU, 0, 0, 0, 0, S_RUN));
    ifa.lsu_mem_ack = 1'b1;
    drive("trp_ack", ev(P_NONE, 0, 0, 0, 0, S_MEM));
    idle();
    drive("trp_after", ev(P_NONE, 0, 0, 0, 0, S_RUN));

    // priority: memory > branch > mul/div > load-use
    lu_inputs();
    ifa.de_is_muldiv = 1'b1;
    mem_inputs();
    ifa.el_taken = 1'b1;
    drive("prio_mem", ev(P_LSU, 0, 0, 0, 0, S_RUN));
    ifa.lsu_mem_ack = 1'b1;
    drive("prio_br", ev(P_NONE, 1, 0, 0, 0, S_MEM));
    ifa.lsu_mem_ack = 1'b0;
    ifa.el_valid    = 1'b0;
    drive("prio_md", ev(P_EXU, 0, 0, 0, 0, S_RUN));
    idle();
    drive("prio_mdw", ev(P_EXU, 0, 0, 0, 0, S_MD));
    ifa.md_done = 1'b1;
    drive("prio_mdd", ev(P_NONE, 0, 0, 0, 0, S_MD));
    idle();
    drive("prio_after", ev(P_NONE, 0, 0, 0, 0, S_RUN));

    // asynchronous reset mid MEM_WAIT
    mem_inputs();
    drive("rm0", ev(P_LSU, 0, 0, 0, 0, S_RUN));
    drive("rm1", ev(P_LSU, 0, 0, 0, 0, S_MEM));
    core_rst = 1'b1;
    exp_en   = 1'b0;
    drive("rst_mid", ev(P_NONE, 0, 0, 0, 0, S_RUN));
    idle();
    core_rst = 1'b0;
    drive("rst_mid_rel", ev(P_NONE, 0, 0, 0, 0, S_RUN));
    exp_en = 1'b1;
    drive("rst_mid_en", ev(P_NONE, 0, 0, 0, 0, S_RUN));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
